// File: rtl/fp_normalize_round.sv
// fp_normalize_round: post-add stage of the FP add/sub datapath.
// Takes the raw, unnormalized sum/difference from the add/sub core, normalizes
// it one bit per cycle, rounds to nearest-even and packs a binary32 result.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      input handshake
//   in_sign, in_exp, in_mant raw operand ({carry, hidden, fraction, G, R, S})
//   in_is_nan, in_is_inf     special results detected by the core
//   out_valid / out_ready    output handshake
//   result                   packed IEEE-754 result
//   overflow, underflow, inexact  exception flags, valid with result
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | left-shifting until the hidden bit is set or exponent bottoms out
// ROUND | round-to-nearest-even and pack
// OUT   | result presented, waiting for out_ready
module fp_normalize_round #(
  parameter int WIDTH     = 32,
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_BITS-1:0]    in_exp,
  input  logic [MANT_BITS+4:0]   in_mant,
  input  logic                   in_is_nan,
  input  logic                   in_is_inf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact
);

  localparam int MW = MANT_BITS + 5;
  localparam int EW = EXP_BITS + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam logic [EW-1:0]    EXP_ONE = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0]    EXP_MAX = {1'b0, {EXP_BITS{1'b1}}};
  localparam logic [WIDTH-1:0] QNAN    = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

  logic [1:0]    state;
  logic [MW-1:0] mant_q;
  logic [EW-1:0] exp_q;
  logic          sign_q;

  // Rounding datapath. The exponent is kept one bit wider than the field so
  // that both the carry-shift (254+1) and the rounding carry into the
  // all-ones exponent are seen as overflow.
  logic [MANT_BITS-1:0]    frac;
  logic                    g_bit, r_bit, s_bit, rnd, lost;
  logic [EW+MANT_BITS-1:0] rsum;
  logic [EW-1:0]           rexp;
  logic                    rovf;

  assign frac  = mant_q[MANT_BITS+2:3];
  assign g_bit = mant_q[2];
  assign r_bit = mant_q[1];
  assign s_bit = mant_q[0];
  assign lost  = g_bit | r_bit | s_bit;
  assign rnd   = g_bit & (r_bit | s_bit | frac[0]);
  // One add over {exp, fraction}: fraction overflow bumps the exponent and a
  // denormal that rounds up to 1.0 lands on exponent 1 without special casing.
  assign rsum  = {exp_q, frac} + {{(EW+MANT_BITS-1){1'b0}}, rnd};
  assign rexp  = rsum[EW+MANT_BITS-1 -: EW];
  assign rovf  = (rexp >= EXP_MAX);

  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mant_q    <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q    <= in_sign;
            mant_q    <= in_mant;
            exp_q     <= {1'b0, in_exp};
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
            if (in_is_nan) begin
              result    <= QNAN;
              out_valid <= 1'b1;
              state     <= OUT;
            end else if (in_is_inf) begin
              result    <= {in_sign, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
              out_valid <= 1'b1;
              state     <= OUT;
            end else if (in_mant == '0) begin
              result    <= '0;
              out_valid <= 1'b1;
              state     <= OUT;
            end else if (in_mant[MW-1]) begin
              // Right shift keeps the dropped bit alive in sticky.
              mant_q <= {1'b0, in_mant[MW-1:2], in_mant[1] | in_mant[0]};
              exp_q  <= {1'b0, in_exp} + EXP_ONE;
              state  <= ROUND;
            end else if (in_mant[MW-2]) begin
              state <= ROUND;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (mant_q[MW-2]) begin
            state <= ROUND;
          end else if (exp_q > EXP_ONE) begin
            mant_q <= {mant_q[MW-2:0], 1'b0};
            exp_q  <= exp_q - EXP_ONE;
          end else begin
            // Exponent already at the minimum: encode as denormal.
            exp_q <= '0;
            state <= ROUND;
          end
        end
        ROUND: begin
          if (rovf) begin
            result <= {sign_q, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
          end else begin
            result <= {sign_q, rsum[EXP_BITS+MANT_BITS-1:0]};
          end
          overflow  <= rovf;
          inexact   <= lost;
          underflow <= lost && (exp_q[EXP_BITS-1:0] == '0);
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed bench for fp_normalize_round: each vector carries hand-computed
// result, flags and the edge after which out_valid must appear.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        in_is_nan;
  logic        in_is_inf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fp_normalize_round #(.WIDTH(32), .EXP_BITS(8), .MANT_BITS(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_is_nan (in_is_nan),
    .in_is_inf (in_is_inf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
  endtask

  // Sends one operand, measures latency from E0, checks result/flags, then
  // optionally holds out_ready low for some cycles before accepting.
  task automatic run_op(input string tag, input logic sign, input logic [7:0] exp,
                        input logic [27:0] mant, input logic nan, input logic inf,
                        input int want_lat, input logic [31:0] want_res,
                        input logic want_ovf, input logic want_unf, input logic want_inx,
                        input int hold);
    int wait_n;
    int lat;
    logic [31:0] held;
    @(negedge clk);
    wait_n = 0;
    while (!in_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_sign   = sign;
    in_exp    = exp;
    in_mant   = mant;
    in_is_nan = nan;
    in_is_inf = inf;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, ".busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".lat"},  32'(lat),       32'(want_lat));
    check({tag, ".res"},  result,         want_res);
    check({tag, ".ovf"},  32'(overflow),  32'(want_ovf));
    check({tag, ".unf"},  32'(underflow), 32'(want_unf));
    check({tag, ".inx"},  32'(inexact),   32'(want_inx));
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_res"},   result,          held);
      check({tag, ".hold_valid"}, 32'(out_valid),  32'd1);
      check({tag, ".hold_ready"}, 32'(in_ready),   32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".drain"}, 32'(out_valid), 32'd0);
    check({tag, ".idle"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_is_nan = 1'b0;
    in_is_inf = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.res",   result,         32'd0);
    check("rst.ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.release_ready", 32'(in_ready), 32'd1);

    //      tag         s  exp   mant          nan  inf  lat result        ovf unf inx hold
    run_op("norm",     0, 127, 28'h4000000, 0, 0, 1, 32'h3F800000, 0, 0, 0, 0);
    run_op("carry",    0, 127, 28'h8000000, 0, 0, 1, 32'h40000000, 0, 0, 0, 0);
    run_op("carryovf", 0, 254, 28'h8000000, 0, 0, 1, 32'h7F800000, 1, 0, 0, 0);
    run_op("lshift4",  0, 127, 28'h0400000, 0, 0, 6, 32'h3D800000, 0, 0, 0, 5);
    run_op("tie_up",   0, 127, 28'h7FFFFFC, 0, 0, 1, 32'h40000000, 0, 0, 1, 0);
    run_op("denorm",   0, 1,   28'h0000008, 0, 0, 2, 32'h00000001, 0, 0, 0, 0);
    run_op("nan",      1, 5,   28'h0000123, 1, 0, 0, 32'h7FC00000, 0, 0, 0, 0);
    run_op("ninf",     1, 5,   28'h0000123, 0, 1, 0, 32'hFF800000, 0, 0, 0, 0);
    run_op("zero",     1, 100, 28'h0000000, 0, 0, 0, 32'h00000000, 0, 0, 0, 0);
    run_op("tie_even", 1, 127, 28'h4000004, 0, 0, 1, 32'hBF800000, 0, 0, 1, 0);
    run_op("gr_up",    0, 127, 28'h4000006, 0, 0, 1, 32'h3F800001, 0, 0, 1, 0);
    run_op("carry_g",  0, 127, 28'h8000008, 0, 0, 1, 32'h40000000, 0, 0, 1, 0);
    run_op("carry_s",  0, 127, 28'h8000009, 0, 0, 1, 32'h40000001, 0, 0, 1, 0);
    run_op("dn_promo", 0, 1,   28'h3FFFFFC, 0, 0, 2, 32'h00800000, 0, 1, 1, 0);
    run_op("dn_unf",   0, 1,   28'h000000C, 0, 0, 2, 32'h00000002, 0, 1, 1, 0);
    run_op("exp_floor",0, 3,   28'h0400000, 0, 0, 4, 32'h00200000, 0, 0, 0, 0);
    run_op("rnd_ovf",  0, 254, 28'h7FFFFFC, 0, 0, 1, 32'h7F800000, 1, 0, 1, 0);

    // Reset while normalizing: previous result is nonzero, so a cleared
    // result shows the asynchronous reset took effect.
    @(negedge clk);
    in_sign   = 1'b0;
    in_exp    = 8'd127;
    in_mant   = 28'h0400000;
    in_is_nan = 1'b0;
    in_is_inf = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst.valid", 32'(out_valid), 32'd0);
    check("midrst.res",   result,         32'd0);
    check("midrst.ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.release_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("midrst.no_output", 32'(out_valid), 32'd0);
    run_op("post_rst", 0, 127, 28'h4000000, 0, 0, 1, 32'h3F800000, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Post-add stage of the FP add/sub datapath. Consumes the raw, unnormalized sum/difference from the add/sub core and produces a packed IEEE-754 binary32 result plus exception flags.
- Normalization is iterative: one bit per cycle, driven by an FSM.
- Rounding is round-to-nearest-even.
- Both sides use valid/ready handshakes, so the stage can stall the core.

Parameters:
- WIDTH, 32, packed result width; must equal 1+EXP_BITS+MANT_BITS.
- EXP_BITS, 8, exponent field width.
- MANT_BITS, 23, fraction field width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  raw operand valid
- in_ready  out  1  stage can accept
- in_sign  in  1  result sign
- in_exp  in  EXP_BITS  biased exponent of larger operand; 1..2^EXP_BITS-2 for non-special input (core maps denormal exponent 0 to 1)
- in_mant  in  MANT_BITS+5  raw mantissa, fields as follows:
  - [MANT_BITS+4]: carry
  - [MANT_BITS+3]: hidden
  - [MANT_BITS+2:3]: fraction
  - [2]: guard G
  - [1]: round R
  - [0]: sticky S
- in_is_nan  in  1  core detected NaN result
- in_is_inf  in  1  core detected infinite result (sign in in_sign)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- result  out  WIDTH  packed result
- overflow  out  1  finite inputs rounded to infinity
- underflow  out  1  tiny and inexact result
- inexact  out  1  G|R|S nonzero at rounding

Behaviour:
- Reset: rst is asynchronous and active-high. It forces state IDLE and clears out_valid, result, overflow, underflow and inexact to 0. Reset mid-operation discards the in-flight operand. in_ready=0 while rst is high.
- in_ready = (state==IDLE) && !rst, combinational from state. A transfer occurs on a clock edge with in_valid && in_ready. That edge is E0.
- FSM states: IDLE, NORM, ROUND, OUT.
- IDLE, on transfer, first matching case:
  - in_is_nan: result=0x7FC00000 (canonical, sign 0), flags 0, go OUT.
  - in_is_inf: result={in_sign, all-ones exponent, 0}, flags 0, go OUT.
  - in_mant==0: result=+0 (all zero), flags 0, go OUT.
  - carry=1: mant>>=1 with the shifted-out bit ORed into S; exp+=1; go ROUND.
  - hidden=1: go ROUND.
  - otherwise: go NORM.
- NORM, evaluated once per cycle:
  - hidden=1: go ROUND.
  - hidden=0 and exp>1: mant<<=1 (S shifts into R, 0 into S); exp-=1; stay in NORM.
  - hidden=0 and exp==1: exp=0 (denormal encoding); go ROUND.
  - At most MANT_BITS+1 shift cycles.
- ROUND:
  - lsb = fraction[0]; rnd = G & (R|S|lsb).
  - {exp,fraction} += rnd as one concatenated add. Its carries handle fraction overflow (exp+1) and denormal-to-normal promotion.
  - If the resulting exp == all ones: result=±inf, overflow=1.
  - inexact = G|R|S.
  - underflow = inexact && (exp field==0 before rounding).
  - Go OUT.
- OUT:
  - out_valid=1. result and flags are held stable until out_valid && out_ready.
  - On that edge, clear out_valid and go IDLE. Acceptance of a new input resumes on the next cycle.
- Latency, out_valid visible after the listed edge:
  - special/zero: after E0.
  - normalized or carry input: after E1.
  - k≥1 left shifts, or denormal entry: after E(k+2).
- Throughput: one operation in flight. No input is accepted while in NORM, ROUND or OUT.
- Width rules: exp arithmetic uses EXP_BITS+1 bits internally so the carry-shift into all-ones is detected (254+1 gives overflow). The concatenated rounding add uses EXP_BITS+MANT_BITS+1 bits.

Test Plan:
- Normalized: in_mant=0x4000000, exp=127, sign 0 -> result 0x3F800000, out_valid after E1, all flags 0.
- Carry right-shift (1.0+1.0): in_mant=0x8000000, exp=127 -> result 0x40000000 after E1. Then exp=254 with the same mant -> 0x7F800000, overflow=1.
- Left normalization: in_mant=0x0400000, exp=127 -> 4 shifts, result 0x3D800000, out_valid after E6.
- Rounding tie-to-even with mantissa overflow: in_mant=0x7FFFFFC, exp=127 -> result 0x40000000, inexact=1, overflow=0.
- Denormal/specials:
  - in_mant=0x0000008, exp=1 -> result 0x00000001 after E2, underflow=0.
  - in_is_nan=1 -> 0x7FC00000 after E0.
  - in_is_inf=1, sign 1 -> 0xFF800000.
- Handshake/reset:
  - Hold out_ready=0 for 5 cycles in OUT -> result stable, in_ready=0.
  - Assert rst in NORM -> out_valid=0 and result=0 immediately. After release, state IDLE and in_ready=1.
